pipe_hazard_ctrl: RTL
=====================

# pipe_hazard_ctrl

Pipeline sequencing controller for the 5-stage integer core: it decides, every cycle, whether PC, the fetch/decode register and the decode/execute register advance, hold, or are squashed. It handles three cases: load-use stalls on `ldw` results, wrong-path squashing after a taken `br`/`blt` resolved in decode, and multi-cycle `MUL` occupancy of the execute stage. It sits beside the decode stage, consumes decoded operand/opcode information plus the execute-stage destination, and drives the stage enables. It also keeps a saturating stall-cycle counter for performance measurement.

## Interface
Parameters:
- `MUL_LAT`, default 3: cycles a MUL occupies execute (legal range 1–15).
- `BR_FLUSH`, default 1: fetch/decode squash cycles after a taken branch (legal range 1–15).
- `CNT_W`, default 16: width of the stall counter.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `dec_valid` in 1: decode holds a real instruction; 0 means bubble.
- `dec_rA` in 5: source register A of the decode instruction.
- `dec_rB` in 5: source register B of the decode instruction.
- `dec_use_rA` in 1: the decode instruction reads rA.
- `dec_use_rB` in 1: the decode instruction reads rB.
- `dec_is_mul` in 1: the decode instruction is R-type opx 39 (MUL).
- `dec_branch_taken` in 1: decode resolved a taken br/blt this cycle.
- `exe_mem_rd` in 1: the instruction in execute is `ldw`.
- `exe_reg_wr_add` in 5: destination register of the execute instruction.
- `pc_en` out 1: PC may update.
- `fd_en` out 1: fetch/decode register may load.
- `fd_flush` out 1: fetch/decode register loads a NOP (dec_valid=0) instead of the fetched word.
- `de_bubble` out 1: decode/execute register loads all-zero control signals (no reg_wr/mem_wr/mem_rd).
- `ctrl_state` out 2: current FSM state (RUN=0, MULWAIT=1, FLUSH=2).
- `stall_cycles` out CNT_W: count of cycles with pc_en=0.

## Operation
Hazard definition:
- `ld_haz` = dec_valid & exe_mem_rd & (exe_reg_wr_add != 0) & ((dec_use_rA & dec_rA==exe_reg_wr_add) | (dec_use_rB & dec_rB==exe_reg_wr_add)).
- Register 0 never creates a hazard.

State RUN (Mealy outputs), priority in this order:
- ld_haz: pc_en=0, fd_en=0, de_bubble=1, fd_flush=0. Stay in RUN. A branch in decode is not honoured this cycle; it is re-evaluated next cycle with the forwarded operand.
- else dec_valid & dec_branch_taken: pc_en=1, fd_en=1, fd_flush=1, de_bubble=0.
  - If BR_FLUSH>1: go to FLUSH with cnt=BR_FLUSH-1.
  - Else stay in RUN.
- else dec_valid & dec_is_mul: the MUL advances (all enables 1, no flush/bubble).
  - If MUL_LAT>1: go to MULWAIT with cnt=MUL_LAT-1.
  - Else stay in RUN.
- else: pc_en=1, fd_en=1, fd_flush=0, de_bubble=0.

State MULWAIT:
- Outputs: pc_en=0, fd_en=0, de_bubble=1, fd_flush=0.
- cnt decrements each cycle; go to RUN on the cycle cnt==1.
- Decode inputs are ignored (no branch or hazard evaluation).

State FLUSH:
- Outputs: pc_en=1, fd_en=1, fd_flush=1, de_bubble=0.
- cnt decrements; go to RUN on the cycle cnt==1.
- dec_branch_taken is ignored, because decode holds a squashed NOP.

cnt is 4 bits and is cleared on return to RUN.

stall_cycles:
- Increments by 1 on every rising edge where pc_en==0 and rst==0.
- Saturates at 2^CNT_W-1 and never wraps.

## Timing
- Reset: while rst=1, the state is RUN, cnt=0, stall_cycles=0, and the outputs are forced to pc_en=0, fd_en=0, fd_flush=1, de_bubble=1, ctrl_state=0.
- Reset asserted mid-MULWAIT or mid-FLUSH aborts immediately; after rst falls, operation starts in RUN.
- pc_en, fd_en, fd_flush and de_bubble are combinational from the state and the same-cycle inputs, with zero latency; the consuming registers sample them on the next edge.
- ctrl_state and stall_cycles are registered.
- Load-use costs exactly 1 stall cycle per occurrence.
- MUL costs MUL_LAT-1 stall cycles after its issue cycle.
- A taken branch squashes BR_FLUSH fetched words.
- A back-to-back MUL after MULWAIT is evaluated normally in the RUN cycle that follows.

## Test plan
- Load-use: exe_mem_rd=1, exe_reg_wr_add=5; decode addi with dec_rA=5, dec_use_rA=1 -> one cycle of pc_en=0, fd_en=0, de_bubble=1; stall_cycles goes 0->1; the next cycle (exe_mem_rd=0) has all enables 1.
- r0 immunity: the same stimulus with exe_reg_wr_add=0 and dec_rA=0 -> no stall, and stall_cycles stays 0.
- MUL with MUL_LAT=3: dec_is_mul=1 -> issue cycle with enables 1, then 2 cycles in MULWAIT (ctrl_state=1, pc_en=0, de_bubble=1), then RUN; stall_cycles=2.
- Branch with BR_FLUSH=2: dec_branch_taken=1 -> fd_flush=1 on that cycle and the next (ctrl_state=2), pc_en=1 throughout, then RUN; a dec_branch_taken pulse during FLUSH is ignored.
- Priority: ld_haz and dec_branch_taken in the same cycle -> stall only (fd_flush=0); the branch is honoured the following cycle with fd_flush=1.
- Reset mid-MULWAIT with CNT_W=4: preload stall_cycles to 15 and verify it holds at 15 (saturation) on a further stall; assert rst during MULWAIT -> outputs forced as specified, stall_cycles=0, and RUN with all enables 1 after release.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - decode-side hazard bundle between pipeline and sequencing controller
//
// Purpose: groups the decode/execute hazard information flowing into the
// controller and the stage enables / status flowing back to the pipeline.
// Ports (as signals of the bundle):
//   dec_valid, dec_rA, dec_rB, dec_use_rA, dec_use_rB, dec_is_mul,
//   dec_branch_taken, exe_mem_rd, exe_reg_wr_add   : pipeline -> controller
//   pc_en, fd_en, fd_flush, de_bubble, ctrl_state,
//   stall_cycles                                   : controller -> pipeline
// master = pipeline side, slave = controller side.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             dec_valid;
  logic [4:0]       dec_rA;
  logic [4:0]       dec_rB;
  logic             dec_use_rA;
  logic             dec_use_rB;
  logic             dec_is_mul;
  logic             dec_branch_taken;
  logic             exe_mem_rd;
  logic [4:0]       exe_reg_wr_add;
  logic             pc_en;
  logic             fd_en;
  logic             fd_flush;
  logic             de_bubble;
  logic [1:0]       ctrl_state;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output dec_valid, dec_rA, dec_rB, dec_use_rA, dec_use_rB, dec_is_mul,
           dec_branch_taken, exe_mem_rd, exe_reg_wr_add,
    input  pc_en, fd_en, fd_flush, de_bubble, ctrl_state, stall_cycles
  );

  modport slave (
    input  dec_valid, dec_rA, dec_rB, dec_use_rA, dec_use_rB, dec_is_mul,
           dec_branch_taken, exe_mem_rd, exe_reg_wr_add,
    output pc_en, fd_en, fd_flush, de_bubble, ctrl_state, stall_cycles
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - PC/FD/DE sequencing for load-use, taken-branch squash and MUL occupancy
//
// Purpose: decides each cycle whether PC and the FD/DE registers advance,
// hold or are squashed, and counts cycles in which PC is held.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   hz   : pipe_hazard_ctrl_if.slave (decode/execute hazard info in,
//          stage enables, ctrl_state and stall_cycles out)
module pipe_hazard_ctrl #(
  parameter int MUL_LAT  = 3,
  parameter int BR_FLUSH = 1,
  parameter int CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  pipe_hazard_ctrl_if.slave  hz
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MULWAIT = 2'd1,
    FLUSH   = 2'd2
  } state_t;

  localparam logic [3:0] MUL_CNT = 4'(MUL_LAT - 1);
  localparam logic [3:0] BR_CNT  = 4'(BR_FLUSH - 1);

  state_t           state, state_nx;
  logic [3:0]       cnt, cnt_nx;
  logic [CNT_W-1:0] stall_q;
  logic             ld_haz;
  logic             pc_en_c, fd_en_c, fd_flush_c, de_bubble_c;

  // Register 0 is hardwired, so a load targeting it never blocks decode.
  assign ld_haz = hz.dec_valid && hz.exe_mem_rd && (hz.exe_reg_wr_add != 5'd0) &&
                  ((hz.dec_use_rA && (hz.dec_rA == hz.exe_reg_wr_add)) ||
                   (hz.dec_use_rB && (hz.dec_rB == hz.exe_reg_wr_add)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      cnt   <= 4'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    pc_en_c     = 1'b1;
    fd_en_c     = 1'b1;
    fd_flush_c  = 1'b0;
    de_bubble_c = 1'b0;
    case (state)
      RUN: begin
        // Load-use wins over a branch: the branch compare may depend on the
        // loaded value, so it is re-evaluated once the operand is forwarded.
        if (ld_haz) begin
          pc_en_c     = 1'b0;
          fd_en_c     = 1'b0;
          de_bubble_c = 1'b1;
        end else if (hz.dec_valid && hz.dec_branch_taken) begin
          fd_flush_c = 1'b1;
          if (BR_FLUSH > 1) begin
            state_nx = FLUSH;
            cnt_nx   = BR_CNT;
          end
        end else if (hz.dec_valid && hz.dec_is_mul) begin
          if (MUL_LAT > 1) begin
            state_nx = MULWAIT;
            cnt_nx   = MUL_CNT;
          end
        end
      end
      MULWAIT: begin
        pc_en_c     = 1'b0;
        fd_en_c     = 1'b0;
        de_bubble_c = 1'b1;
        if (cnt == 4'd1) begin
          state_nx = RUN;
          cnt_nx   = 4'd0;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      FLUSH: begin
        fd_flush_c = 1'b1;
        if (cnt == 4'd1) begin
          state_nx = RUN;
          cnt_nx   = 4'd0;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      default: begin
        state_nx = RUN;
        cnt_nx   = 4'd0;
      end
    endcase
  end

  // While reset is held the pipeline is frozen with bubbles and NOPs.
  assign hz.pc_en     = rst ? 1'b0 : pc_en_c;
  assign hz.fd_en     = rst ? 1'b0 : fd_en_c;
  assign hz.fd_flush  = rst ? 1'b1 : fd_flush_c;
  assign hz.de_bubble = rst ? 1'b1 : de_bubble_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else if (!pc_en_c && (stall_q != {CNT_W{1'b1}})) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  assign hz.ctrl_state   = state;
  assign hz.stall_cycles = stall_q;

endmodule
